// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: round-robin between the
// core (m0) and the debug/loader port (m1), with a bounded m1 lock.
module dram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int LOCK_MAX   = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [BE_WIDTH-1:0]   m0_be,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_data,

  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [BE_WIDTH-1:0]   m1_be,
  input  logic                  m1_lock,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_data,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_e;

  localparam logic [6:0] LOCK_LIMIT = 7'(LOCK_MAX);

  lock_state_e lock_state;
  logic        last_m1;   // 1: m1 held the most recent grant
  logic [6:0]  lock_cnt;
  logic        rsp0_q;
  logic        rsp1_q;
  logic        grant0;
  logic        grant1;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (lock_state == ST_LOCKED) begin
        if (m0_valid && lock_cnt >= LOCK_LIMIT) grant0 = 1'b1;
        else if (m1_valid)                      grant1 = 1'b1;
        else                                    grant0 = m0_valid;
      end else if (m0_valid && m1_valid) begin
        grant0 = last_m1;
        grant1 = !last_m1;
      end else begin
        grant0 = m0_valid;
        grant1 = m1_valid;
      end
    end
  end

  assign m0_ready = grant0;
  assign m1_ready = grant1;

  always_comb begin
    ram_addr       = '0;
    ram_wr_data    = '0;
    ram_wr_en      = 1'b0;
    ram_wr_byte_en = '0;
    if (grant0) begin
      ram_addr       = m0_addr;
      ram_wr_data    = m0_wdata;
      ram_wr_en      = m0_we;
      ram_wr_byte_en = m0_we ? m0_be : '0;
    end else if (grant1) begin
      ram_addr       = m1_addr;
      ram_wr_data    = m1_wdata;
      ram_wr_en      = m1_we;
      ram_wr_byte_en = m1_we ? m1_be : '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= ST_OPEN;
      last_m1    <= 1'b1;
      lock_cnt   <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
    end else begin
      rsp0_q <= grant0 && !m0_we;
      rsp1_q <= grant1 && !m1_we;

      if (grant0)      last_m1 <= 1'b0;
      else if (grant1) last_m1 <= 1'b1;

      if (grant1) lock_state <= m1_lock ? ST_LOCKED : ST_OPEN;

      // Only locked m1 grants that keep m0 waiting move the starvation counter.
      if (lock_state == ST_LOCKED && m0_valid && grant1 && m1_lock)
        lock_cnt <= lock_cnt + 7'd1;
      else
        lock_cnt <= '0;
    end
  end

  // A read granted just before reset must not surface while reset is high.
  assign m0_rsp_valid = rsp0_q && !rst;
  assign m1_rsp_valid = rsp1_q && !rst;
  assign m0_rsp_data  = m0_rsp_valid ? ram_rd_data : '0;
  assign m1_rsp_data  = m1_rsp_valid ? ram_rd_data : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboarded bench for dram_arbiter: two port drivers, a behavioural RAM,
// a shadow memory predicting read data, and a grant log for ordering checks.
module tb_dram_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic          lock;
    logic          kill;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          tb_rst;
  logic          m_valid [2];
  logic          m_ready [2];
  logic          m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [BW-1:0] m_be    [2];
  logic          m1_lock;
  logic          m_rsp_valid [2];
  logic [DW-1:0] m_rsp_data  [2];
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic [BW-1:0] ram_wr_byte_en;
  logic [DW-1:0] ram_rd_data;

  cmd_t          cmd_q [2][$];
  exp_t          exp_q [2][$];
  int            grant_log [$];
  bit            busy [2];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] last_rsp [2];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  dram_arbiter dut (
    .clk            (clk),
    .rst            (tb_rst),
    .m0_valid       (m_valid[0]),
    .m0_ready       (m_ready[0]),
    .m0_we          (m_we[0]),
    .m0_addr        (m_addr[0]),
    .m0_wdata       (m_wdata[0]),
    .m0_be          (m_be[0]),
    .m0_rsp_valid   (m_rsp_valid[0]),
    .m0_rsp_data    (m_rsp_data[0]),
    .m1_valid       (m_valid[1]),
    .m1_ready       (m_ready[1]),
    .m1_we          (m_we[1]),
    .m1_addr        (m_addr[1]),
    .m1_wdata       (m_wdata[1]),
    .m1_be          (m_be[1]),
    .m1_lock        (m1_lock),
    .m1_rsp_valid   (m_rsp_valid[1]),
    .m1_rsp_data    (m_rsp_data[1]),
    .ram_addr       (ram_addr),
    .ram_wr_data    (ram_wr_data),
    .ram_wr_en      (ram_wr_en),
    .ram_wr_byte_en (ram_wr_byte_en),
    .ram_rd_data    (ram_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural single-port RAM, one-cycle read latency.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 ^ DW'(i);
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < BW; b++)
        if (ram_wr_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
    ram_rd_data <= mem[ram_addr];
  end

  task automatic drive_port(input int p);
    cmd_t c;
    bit   granted;
    int   waited;
    forever begin
      if (cmd_q[p].size() == 0) begin
        busy[p] = 1'b0;
        m_valid[p] = 1'b0;
        m_we[p] = 1'b0;
        m_addr[p] = '0;
        m_wdata[p] = '0;
        m_be[p] = '0;
        if (p == 1) m1_lock = 1'b0;
        @(posedge clk); #1;
      end else begin
        c = cmd_q[p].pop_front();
        busy[p] = 1'b1;
        m_valid[p] = 1'b1;
        m_we[p] = c.we;
        m_addr[p] = c.addr;
        m_wdata[p] = c.data;
        m_be[p] = c.be;
        if (p == 1) m1_lock = c.lock;
        granted = 1'b0;
        waited = 0;
        while (!granted && waited < 1000) begin
          @(negedge clk);
          if (m_ready[p] === 1'b1) granted = 1'b1;
          else waited++;
        end
        if (!granted) check("grant_timeout", 0, 1);
        else begin
          grant_log.push_back(p);
          if (c.we) begin
            for (int b = 0; b < BW; b++)
              if (c.be[b]) shadow[c.addr][8*b +: 8] = c.data[8*b +: 8];
          end else if (!c.kill) begin
            exp_q[p].push_back('{data: shadow[c.addr], cyc: cyc + 1});
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Per-cycle protocol checks and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    check("one_grant", {31'd0, m_ready[0] & m_ready[1]}, 0);
    if (!m_ready[0] && !m_ready[1]) begin
      check("idle_wr_en", {31'd0, ram_wr_en}, 0);
      check("idle_addr", {19'd0, ram_addr}, 0);
      check("idle_be", {28'd0, ram_wr_byte_en}, 0);
    end
    for (int p = 0; p < 2; p++) begin
      if (m_ready[p]) begin
        check("ram_addr", {19'd0, ram_addr}, {19'd0, m_addr[p]});
        check("ram_wr_en", {31'd0, ram_wr_en}, {31'd0, m_we[p]});
        check("ram_be", {28'd0, ram_wr_byte_en}, m_we[p] ? {28'd0, m_be[p]} : 0);
        if (m_we[p]) check("ram_wdata", ram_wr_data, m_wdata[p]);
      end
      if (m_rsp_valid[p]) begin
        last_rsp[p] = m_rsp_data[p];
        if (exp_q[p].size() == 0) check(p ? "rsp1_unexpected" : "rsp0_unexpected", 1, 0);
        else begin
          e = exp_q[p].pop_front();
          check(p ? "rsp1_data" : "rsp0_data", m_rsp_data[p], e.data);
          check(p ? "rsp1_cycle" : "rsp0_cycle", cyc, e.cyc);
        end
      end else begin
        check(p ? "rsp1_idle_data" : "rsp0_idle_data", m_rsp_data[p], 0);
      end
    end
  end

  task automatic push(input int p, input logic we, input int addr, input logic [DW-1:0] data,
                      input logic [BW-1:0] be, input logic lock, input logic kill);
    cmd_q[p].push_back('{we: we, addr: AW'(addr), data: data, be: be, lock: lock, kill: kill});
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < budget) begin
      @(negedge clk);
      n++;
      if (cmd_q[0].size() == 0 && cmd_q[1].size() == 0 && !busy[0] && !busy[1] &&
          exp_q[0].size() == 0 && exp_q[1].size() == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 2) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset(input int n);
    tb_rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    tb_rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int w;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 32'hA5A5_0000 ^ DW'(i);
    tb_rst = 1'b1;
    fork
      drive_port(0);
      drive_port(1);
    join_none

    @(negedge clk);
    check("reset_ready0", {31'd0, m_ready[0]}, 0);
    check("reset_ready1", {31'd0, m_ready[1]}, 0);
    check("reset_rsp0", {31'd0, m_rsp_valid[0]}, 0);
    check("reset_rsp1", {31'd0, m_rsp_valid[1]}, 0);
    check("reset_wr_en", {31'd0, ram_wr_en}, 0);
    @(posedge clk); #1;
    do_reset(1);

    // Full-word write then read on m0.
    push(0, 1, 0, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    push(0, 0, 0, 0, 4'b0000, 0, 0);
    wait_idle(100);
    check("req028_data", last_rsp[0], 32'hFFFF_FFFF);

    // Continuous contention after reset alternates starting with m0.
    do_reset(2);
    idx = grant_log.size();
    for (int i = 0; i < 6; i++) begin
      push(0, 0, 100 + i, 0, 4'b0000, 0, 0);
      push(1, 0, 200 + i, 0, 4'b0000, 0, 0);
    end
    wait_idle(200);
    check("rr_count", grant_log.size() - idx, 12);
    for (int i = 0; i < 12; i++) check("rr_order", grant_log[idx + i], i % 2);

    // Byte-lane merge on m1.
    push(1, 1, 5, 32'h1122_3344, 4'b1111, 0, 0);
    push(1, 1, 5, 32'h0000_AB00, 4'b0010, 0, 0);
    push(1, 0, 5, 0, 4'b0000, 0, 0);
    wait_idle(100);
    check("req030_data", last_rsp[1], 32'h1122_AB44);

    // m1 locks alone, then streams locked reads while m0 waits.
    push(1, 0, 10, 0, 4'b0000, 1, 0);
    wait_idle(100);
    idx = grant_log.size();
    push(0, 0, 20, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 70; i++) push(1, 0, 30 + i, 0, 4'b0000, (i != 69), 0);
    wait_idle(400);
    check("lock_count", grant_log.size() - idx, 71);
    for (int i = 0; i < 71; i++) check("lock_order", grant_log[idx + i], (i == 64) ? 0 : 1);

    // Reset right after an m0 read grant kills its response and restores m0 priority.
    push(0, 0, 7, 0, 4'b0000, 0, 1);
    w = 0;
    while (m_ready[0] !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    check("rst_read_granted", {31'd0, m_ready[0]}, 1);
    @(posedge clk); #1;
    tb_rst = 1'b1;
    @(negedge clk);
    check("rst_kills_rsp0", {31'd0, m_rsp_valid[0]}, 0);
    idx = grant_log.size();
    push(0, 0, 300, 0, 4'b0000, 0, 0);
    push(1, 0, 400, 0, 4'b0000, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_gate_ready0", {31'd0, m_ready[0]}, 0);
    check("rst_gate_ready1", {31'd0, m_ready[1]}, 0);
    check("rst_gate_wr_en", {31'd0, ram_wr_en}, 0);
    @(posedge clk); #1;
    tb_rst = 1'b0;
    wait_idle(100);
    check("rst_first_winner", grant_log[idx], 0);

    // Address sweep: decrementing data written by m0, read back by m1.
    for (int i = 0; i < DEPTH; i++) push(0, 1, i, 32'hFFFF_FFFF - DW'(i), 4'b1111, 0, 0);
    wait_idle(DEPTH + 200);
    for (int i = 0; i < DEPTH; i++) push(1, 0, i, 0, 4'b0000, 0, 0);
    wait_idle(DEPTH + 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, giving the word-address width of the shared data RAM.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width of the shared data RAM.
REQ-003 The block SHALL have parameter BE_WIDTH, default 4, giving the number of write byte enables.
REQ-004 The block SHALL have parameter LOCK_MAX, default 64, giving the maximum number of consecutive m1 grants under lock while m0 waits.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have ports m0_valid (in, 1), m0_ready (out, 1), m0_we (in, 1), m0_addr (in, ADDR_WIDTH), m0_wdata (in, DATA_WIDTH), m0_be (in, BE_WIDTH): the core load/store request port.
REQ-008 The block SHALL have ports m0_rsp_valid (out, 1) and m0_rsp_data (out, DATA_WIDTH): the core read-response port.
REQ-009 The block SHALL have m1_* ports identical to REQ-007 and REQ-008, plus m1_lock (in, 1): the debug/loader port.
REQ-010 The block SHALL have RAM-side ports ram_addr (out, ADDR_WIDTH), ram_wr_data (out, DATA_WIDTH), ram_wr_en (out, 1), ram_wr_byte_en (out, BE_WIDTH) and ram_rd_data (in, DATA_WIDTH), connecting to the single-port RAM with 1-cycle read latency.

Function
REQ-011 The block SHALL grant at most one requester per cycle; mN_ready SHALL be 1 only in the cycle where mN is granted, and is combinational from the valid inputs and arbiter state.
REQ-012 A transfer SHALL occur on a cycle with mN_valid and mN_ready both 1; a requester SHALL hold valid, we, addr, wdata and be stable until that cycle.
REQ-013 In a granted cycle the block SHALL drive ram_addr, ram_wr_data and ram_wr_byte_en from the granted port, and ram_wr_en = granted mN_we.
REQ-014 In a cycle with no grant the block SHALL drive ram_wr_en=0, ram_wr_byte_en=0 and ram_addr=0.
REQ-015 On a granted write, ram_wr_byte_en SHALL equal mN_be, and no response SHALL be produced.
REQ-016 On a granted read, ram_wr_byte_en SHALL be 0; the block SHALL register the owner and assert that owner's mN_rsp_valid for exactly one cycle, the cycle after the grant.
REQ-017 mN_rsp_data SHALL equal ram_rd_data whenever mN_rsp_valid=1, and SHALL be 0 otherwise; responses SHALL have no backpressure.
REQ-018 The block SHALL use round-robin arbitration via a 1-bit last-grant register: when both ports are valid and no lock is active, the port not granted last SHALL win; a lone valid requester SHALL be granted every cycle (back-to-back, no bubbles).
REQ-019 The block SHALL enter LOCKED state when m1 is granted with m1_lock=1.
REQ-020 While LOCKED, m1 SHALL have absolute priority; a cycle with m1_valid=0 SHALL leave m0 eligible for a grant that cycle.
REQ-021 The block SHALL exit LOCKED on an m1 transfer with m1_lock=0.
REQ-022 A 7-bit lock counter SHALL count m1 grants in LOCKED while m0_valid=1, and reset to 0 on exit or when m0_valid=0.
REQ-023 When the lock counter reaches LOCK_MAX, the next cycle with m0_valid=1 SHALL grant m0 once, then clear the counter, with LOCKED retained.
REQ-024 Simultaneous m1 lock release and m0 request SHALL use normal round-robin from the following cycle.

Reset
REQ-025 On a clk edge with rst=1 the block SHALL set last-grant so that m0 wins the first contention, clear LOCKED and the lock counter, and set both rsp_valid to 0.
REQ-026 The block SHALL hold all ready outputs and ram_wr_en at 0 while rst=1, combinationally gated.
REQ-027 A read granted in the cycle before rst asserts SHALL produce no rsp_valid.

Verification
REQ-028 The bench SHALL cover: m0 writes 0xFFFFFFFF to addr 0 with be=4'b1111, then reads addr 0 -> m0_rsp_valid 1 cycle after the read grant, data 0xFFFFFFFF.
REQ-029 The bench SHALL cover: m0 and m1 both continuously reading after reset -> grants alternate m0, m1, m0, ...; each rsp_valid goes only to its owner.
REQ-030 The bench SHALL cover: m1 writes addr 5 with be=4'b0010 and data 0x0000AB00 over an existing 0x11223344 -> readback is 0x1122AB44.
REQ-031 The bench SHALL cover: m1_lock=1 streaming reads with m0_valid held -> m1 gets 64 consecutive grants, m0 gets exactly one grant, then m1 resumes.
REQ-032 The bench SHALL cover: rst asserted the cycle after an m0 read grant -> m0_rsp_valid stays 0; after release, m0 wins the first contention.
REQ-033 The bench SHALL cover: a sweep of all 2**ADDR_WIDTH addresses with decrementing write data via m0, then reads via m1 -> zero mismatches.
